// File: rtl/reg_file_pkg.sv
// Shared CPU package: register-file geometry and the write-trace entry layout.
package reg_file_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int DATA_W    = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [DATA_W-1:0]    pc;
    logic [REG_IDX_W-1:0] wreg;
    logic [DATA_W-1:0]    data;
  } trace_entry_t;

endpackage

// File: rtl/reg_file_if.sv
// Pipeline-facing bus of the register file: writeback port, decode read ports, trace stream.
interface reg_file_if;
  import reg_file_pkg::*;

  logic                 w_regwrite;
  logic [REG_IDX_W-1:0] w_regwreg;
  logic [DATA_W-1:0]    w_regwd;
  logic [DATA_W-1:0]    w_pc;

  logic [REG_IDX_W-1:0] d_a1;
  logic [REG_IDX_W-1:0] d_a2;
  logic [DATA_W-1:0]    d_rd1;
  logic [DATA_W-1:0]    d_rd2;

  logic                 trace_valid;
  logic                 trace_ready;
  logic [DATA_W-1:0]    trace_pc;
  logic [REG_IDX_W-1:0] trace_reg;
  logic [DATA_W-1:0]    trace_data;
  logic                 trace_overflow;

  modport master (
    output w_regwrite, w_regwreg, w_regwd, w_pc, d_a1, d_a2, trace_ready,
    input  d_rd1, d_rd2, trace_valid, trace_pc, trace_reg, trace_data, trace_overflow
  );

  modport slave (
    input  w_regwrite, w_regwreg, w_regwd, w_pc, d_a1, d_a2, trace_ready,
    output d_rd1, d_rd2, trace_valid, trace_pc, trace_reg, trace_data, trace_overflow
  );

endinterface

// File: rtl/reg_file_trace_fifo.sv
// trace_fifo: power-of-two deep FIFO of write-trace entries with valid/ready pop
// and a sticky overflow flag for pushes dropped while full.
module trace_fifo
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  trace_entry_t push_data,
  input  logic         pop_ready,
  output logic         valid,
  output trace_entry_t head,
  output logic         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  trace_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic full;
  logic pop;
  logic push_acc;

  assign valid    = (count != '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop      = valid && pop_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_acc = push && (!full || pop);
  assign head     = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; count gates the head, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_acc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file with two combinational read ports and a write-trace FIFO.
// Optional same-cycle write-to-read bypass is enabled by defining GRF_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_eff;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  trace_entry_t      push_entry;
  trace_entry_t      head;

  assign wr_eff = bus.w_regwrite && (bus.w_regwreg != ZERO_REG);

  // The architecture requires the whole file to clear on reset, so the array is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[bus.w_regwreg] <= bus.w_regwd;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd1 = (bus.d_a1 == ZERO_REG) ? '0 : regs[bus.d_a1];
    rd2 = (bus.d_a2 == ZERO_REG) ? '0 : regs[bus.d_a2];
`ifdef GRF_BYPASS_EN
    // wr_eff already excludes register 0, so r0 can never be bypassed.
    if (wr_eff && (bus.d_a1 == bus.w_regwreg)) rd1 = bus.w_regwd;
    if (wr_eff && (bus.d_a2 == bus.w_regwreg)) rd2 = bus.w_regwd;
`else
`endif
  end

  assign bus.d_rd1 = rd1;
  assign bus.d_rd2 = rd2;

  assign push_entry = '{pc: bus.w_pc, wreg: bus.w_regwreg, data: bus.w_regwd};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_eff),
    .push_data (push_entry),
    .pop_ready (bus.trace_ready),
    .valid     (bus.trace_valid),
    .head      (head),
    .overflow  (bus.trace_overflow)
  );

  assign bus.trace_pc   = head.pc;
  assign bus.trace_reg  = head.wreg;
  assign bus.trace_data = head.data;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: writes, reads, r0 handling, bypass, trace FIFO
// overflow / simultaneous push-pop, and asynchronous reset.
module tb_reg_file;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_file_if bus ();

  reg_file #(.TRACE_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    bus.w_regwrite = 1'b1;
    bus.w_regwreg  = r;
    bus.w_regwd    = d;
    bus.w_pc       = pc;
    tick();
    bus.w_regwrite = 1'b0;
  endtask

  task automatic pop();
    bus.trace_ready = 1'b1;
    tick();
    bus.trace_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc,
                            input logic [4:0] r, input logic [31:0] d);
    #1;
    check({tag, ".valid"}, {31'd0, bus.trace_valid}, 32'd1);
    check({tag, ".pc"},    bus.trace_pc, pc);
    check({tag, ".reg"},   {27'd0, bus.trace_reg}, {27'd0, r});
    check({tag, ".data"},  bus.trace_data, d);
  endtask

  task automatic read1(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.d_a1 = a;
    #1;
    check(tag, bus.d_rd1, exp);
  endtask

  logic [31:0] bypass_exp;

  initial begin
    rst_n           = 1'b0;
    bus.w_regwrite  = 1'b1;
    bus.w_regwreg   = 5'd7;
    bus.w_regwd     = 32'hDEAD_BEEF;
    bus.w_pc        = 32'h0000_0040;
    bus.d_a1        = 5'd7;
    bus.d_a2        = 5'd0;
    bus.trace_ready = 1'b0;

    // Write presented while reset is low must not land.
    tick();
    check("rst.valid",    {31'd0, bus.trace_valid}, 32'd0);
    check("rst.overflow", {31'd0, bus.trace_overflow}, 32'd0);
    check("rst.pc_empty", bus.trace_pc, 32'd0);
    bus.w_regwrite = 1'b0;
    rst_n = 1'b1;
    read1(5'd7, "rst.no_write_r7", 32'd0);
    tick();
    check("rst.valid_after", {31'd0, bus.trace_valid}, 32'd0);

    // Basic write then read next cycle, trace head content, pop to empty.
    wr(5'd5, 32'h1234_5678, 32'h0000_0100);
    read1(5'd5, "wr.r5", 32'h1234_5678);
    check_head("wr.head", 32'h0000_0100, 5'd5, 32'h1234_5678);
    pop();
    check("wr.valid_popped", {31'd0, bus.trace_valid}, 32'd0);
    check("wr.data_empty",   bus.trace_data, 32'd0);

    // Register 0 write is ignored and not traced.
    wr(5'd0, 32'hFFFF_FFFF, 32'h0000_0104);
    read1(5'd0, "r0.read", 32'd0);
    check("r0.no_trace", {31'd0, bus.trace_valid}, 32'd0);

    // Same-cycle write/read of reg 3.
    wr(5'd3, 32'h0000_000A, 32'h0000_0108);
    pop();
    bus.w_regwrite = 1'b1;
    bus.w_regwreg  = 5'd3;
    bus.w_regwd    = 32'h0000_000B;
    bus.w_pc       = 32'h0000_010C;
    bus.d_a2       = 5'd3;
`ifdef GRF_BYPASS_EN
    bypass_exp = 32'h0000_000B;
`else
    bypass_exp = 32'h0000_000A;
`endif
    #1;
    check("byp.same_cycle", bus.d_rd2, bypass_exp);
    tick();
    bus.w_regwrite = 1'b0;
    #1;
    check("byp.next_cycle", bus.d_rd2, 32'h0000_000B);
    pop();

    // Same-cycle write to r0 never bypasses.
    bus.w_regwrite = 1'b1;
    bus.w_regwreg  = 5'd0;
    bus.w_regwd    = 32'h5555_5555;
    read1(5'd0, "byp.r0", 32'd0);
    tick();
    bus.w_regwrite = 1'b0;
    check("byp.r0_no_trace", {31'd0, bus.trace_valid}, 32'd0);

    // Five writes with no consumer: four kept, fifth dropped.
    for (int i = 0; i < 5; i++)
      wr(5'(10 + i), 32'h0000_1000 + i, 32'h0000_0200 + 4 * i);
    check("ovf.flag", {31'd0, bus.trace_overflow}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ovf.drain%0d", i), 32'h0000_0200 + 4 * i,
                 5'(10 + i), 32'h0000_1000 + i);
      pop();
    end
    check("ovf.empty", {31'd0, bus.trace_valid}, 32'd0);
    check("ovf.sticky", {31'd0, bus.trace_overflow}, 32'd1);
    read1(5'd14, "ovf.r14_written", 32'h0000_1004);

    // Async reset between edges with two entries queued.
    wr(5'd20, 32'h0000_00AA, 32'h0000_0300);
    wr(5'd21, 32'h0000_00BB, 32'h0000_0304);
    check("arst.pre_valid", {31'd0, bus.trace_valid}, 32'd1);
    bus.d_a1 = 5'd5;
    bus.d_a2 = 5'd21;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst.valid",    {31'd0, bus.trace_valid}, 32'd0);
    check("arst.overflow", {31'd0, bus.trace_overflow}, 32'd0);
    check("arst.r5",       bus.d_rd1, 32'd0);
    check("arst.r21",      bus.d_rd2, 32'd0);
    rst_n = 1'b1;
    #1;
    read1(5'd14, "arst.r14", 32'd0);

    // Full FIFO, push and pop on the same edge.
    for (int i = 0; i < 4; i++)
      wr(5'(20 + i), 32'h0000_2000 + i, 32'h0000_0400 + 4 * i);
    bus.trace_ready = 1'b1;
    wr(5'd24, 32'h0000_2004, 32'h0000_0410);
    bus.trace_ready = 1'b0;
    check("full.no_overflow", {31'd0, bus.trace_overflow}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("full.drain%0d", i), 32'h0000_0400 + 4 * i,
                 5'(20 + i), 32'h0000_2000 + i);
      pop();
    end
    check("full.empty", {31'd0, bus.trace_valid}, 32'd0);

    // Empty FIFO, push and pop on the same edge: pop ignored.
    bus.trace_ready = 1'b1;
    wr(5'd25, 32'h0000_3000, 32'h0000_0500);
    bus.trace_ready = 1'b0;
    check_head("empty.pushpop", 32'h0000_0500, 5'd25, 32'h0000_3000);
    pop();
    check("empty.one_entry", {31'd0, bus.trace_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter TRACE_DEPTH, default 4, the write-trace FIFO depth, a power of two no less than 2.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have w_regwrite  input  1  write enable from the writeback stage.
REQ-005 SHALL have w_regwreg  input  5  destination register index from the writeback stage.
REQ-006 SHALL have w_regwd  input  32  write data from the writeback stage.
REQ-007 SHALL have w_pc  input  32  PC of the instruction in writeback.
REQ-008 SHALL have d_a1, d_a2  input  5 each  decode-stage read addresses.
REQ-009 SHALL have d_rd1, d_rd2  output  32 each  read data for d_a1 and d_a2.
REQ-010 SHALL have trace_valid  output  1  trace FIFO head is valid.
REQ-011 SHALL have trace_ready  input  1  consumer accepts the trace head.
REQ-012 SHALL have trace_pc, trace_reg, trace_data  output  32/5/32  fields of the trace head entry.
REQ-013 SHALL have trace_overflow  output  1  sticky flag: one or more trace entries were dropped.

Function
REQ-014 SHALL hold 32 registers of 32 bits; register 0 SHALL read 0 at all times and is never written.
REQ-015 SHALL perform an effective write, on the rising edge, when w_regwrite=1 and w_regwreg!=0: reg[w_regwreg] <= w_regwd.
REQ-016 SHALL read d_rd1/d_rd2 combinationally, with zero-cycle latency from d_a1/d_a2.
REQ-017 SHALL push {w_pc, w_regwreg, w_regwd} into the trace FIFO on every effective write, in the same edge.
REQ-018 SHALL pop the FIFO head on an edge where trace_valid=1 and trace_ready=1.
REQ-019 SHALL drive trace_valid=1 exactly when the FIFO is non-empty; the trace_* fields SHALL be 0 when it is empty.
REQ-020 SHALL, when the FIFO is full and a push occurs without a pop, drop the new entry, leave the contents unchanged, and set trace_overflow=1 until reset.
REQ-021 SHALL, when the FIFO is full and a push and a pop occur on the same edge, accept both; the count is unchanged and no overflow is flagged.
REQ-022 SHALL, when the FIFO is empty and a push and a pop occur on the same edge, ignore the pop because trace_valid=0; the count becomes 1.
REQ-023 SHALL wrap the read and write pointers modulo TRACE_DEPTH and track the occupancy count in 0..TRACE_DEPTH.

Reset
REQ-024 SHALL, while rst_n=0, immediately clear all 32 registers to 0, empty the FIFO, and clear trace_overflow, independent of clk.
REQ-025 SHALL, on reset mid-operation, discard pending FIFO entries; a write presented on the edge at which rst_n is still low SHALL NOT take effect.

Configuration
REQ-026 SHALL support macro GRF_BYPASS_EN: when defined, a read whose address equals a same-cycle effective write returns w_regwd; when undefined, such a read returns the stored (old) value.
REQ-027 SHALL never bypass to register 0 with or without GRF_BYPASS_EN defined.

Structure
REQ-028 SHALL take the trace entry struct type, the register count (32) and the zero-register index from the shared CPU package.
REQ-029 SHALL implement the FIFO as sub-module trace_fifo (parameterised depth, valid/ready pop, push with overflow flag).

Verification
REQ-030 SHALL cover this case: write reg 5 = 0x12345678, read d_a1=5 on the next cycle -> d_rd1=0x12345678.
REQ-031 SHALL cover this case: write reg 0 = 0xFFFFFFFF -> d_rd1=0 for d_a1=0, no trace push, trace_valid stays 0.
REQ-032 SHALL cover this case: reg 3 holds 0xA, then write reg 3 = 0xB and read d_a2=3 in the same cycle -> 0xB with GRF_BYPASS_EN defined, 0xA without it.
REQ-033 SHALL cover this case: 5 writes with trace_ready=0, TRACE_DEPTH=4 -> 4 entries held, 5th dropped, trace_overflow=1; then drain -> entries in order with the matching pc/reg/data.
REQ-034 SHALL cover this case: FIFO full, push and pop on the same edge -> occupancy stays 4, trace_overflow stays 0, the new entry appears last.
REQ-035 SHALL cover this case: rst_n pulsed low between clock edges with 2 entries queued -> trace_valid=0 and all registers read 0 immediately.
